// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in/serial-out stream converter.
package piso_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/piso_stream.sv
// Parallel-in/serial-out converter with valid/ready handshakes on both sides,
// selectable bit order, serial stall, last-bit marker and bubble-free reloads.
module piso_stream
  import piso_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             sout,
  output logic             sout_valid,
  input  logic             sout_ready,
  output logic             sout_last,
  output logic             busy
);

  localparam int              CNT_W    = cnt_w(WIDTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_cnt;

  logic             w_busy;
  logic             w_out_bit;
  logic             w_load;
  logic [WIDTH-1:0] w_shifted;

  assign w_busy    = (r_state == SHIFT);
  assign w_out_bit = MSB_FIRST ? r_shreg[WIDTH-1] : r_shreg[0];
  assign w_shifted = MSB_FIRST ? {r_shreg[WIDTH-2:0], 1'b0}
                               : {1'b0, r_shreg[WIDTH-1:1]};

  assign busy       = w_busy;
  assign sout_valid = w_busy;
  assign sout       = w_busy & w_out_bit;
  assign sout_last  = w_busy && (r_cnt == LAST_CNT);

  // Reload is allowed on the edge that consumes the final bit, so streams
  // of words run back to back without an idle cycle in between.
  assign load_ready = !rst && (!w_busy || (sout_last && sout_ready));
  assign w_load     = load_valid && load_ready;

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (w_load) begin
      r_state <= SHIFT;
      r_shreg <= din;
      r_cnt   <= '0;
    end else if (w_busy && sout_ready) begin
      if (sout_last) begin
        r_state <= IDLE;
        r_cnt   <= '0;
      end else begin
        r_shreg <= w_shifted;
        r_cnt   <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule
